// File: rtl/cascade_prefix_pipe_pkg.sv
// Shared types and parameter bounds for the cascaded prefix-reduction pipeline.
package cascade_prefix_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  localparam int unsigned N_CH_MIN         = 2;
  localparam int unsigned N_CH_MAX         = 32;
  localparam int unsigned EXTRA_STAGES_MIN = 0;
  localparam int unsigned EXTRA_STAGES_MAX = 4;

endpackage

// File: rtl/cascade_pipe_stage.sv
// One elastic register slice: valid, data and mode, loaded when the stage may advance.
module cascade_pipe_stage
  import cascade_prefix_pipe_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_adv,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic [1:0]   i_mode,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_mode
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic [1:0]   r_mode;

  // Valid follows the predecessor on advance; payload only moves with a real transaction so
  // the output stays quiet while the pipe idles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= MODE_AND;
    end else if (i_adv) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
        r_mode <= i_mode;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mode  = r_mode;

endmodule

// File: rtl/cascade_prefix_pipe.sv
// Elastic pipeline computing a per-channel prefix AND/OR/XOR (or pass-through) of its input.
module cascade_prefix_pipe
  import cascade_prefix_pipe_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned EXTRA_STAGES = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_CH-1:0] in_data,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_CH-1:0] out_data,
  output logic [1:0]      out_mode
);

  localparam int unsigned L = 2 + EXTRA_STAGES;

  if (N_CH < N_CH_MIN || N_CH > N_CH_MAX || EXTRA_STAGES > EXTRA_STAGES_MAX) begin : g_bad_param
    $error("cascade_prefix_pipe: parameter out of legal range");
  end

  logic [L-1:0]    w_valid;
  logic [L-1:0]    w_adv;
  logic [L-1:0]    w_vin;
  logic [N_CH-1:0] w_data [L];
  logic [N_CH-1:0] w_din  [L];
  logic [1:0]      w_mode [L];
  logic [1:0]      w_min  [L];
  logic [N_CH-1:0] w_prefix;

  // A stage may advance if it or any stage downstream of it is empty, or the consumer takes
  // the head; written flat so each bit depends only on register outputs and out_ready.
  always_comb begin
    w_adv = '0;
    for (int unsigned k = 0; k < L; k++) begin
      logic acc;
      acc = out_ready;
      for (int unsigned j = k; j < L; j++) begin
        acc = acc | ~w_valid[j];
      end
      w_adv[k] = acc;
    end
  end

  // Ripple prefix reduction over the captured S0 word, LSB first.
  always_comb begin
    logic acc;
    w_prefix = w_data[0];
    acc      = w_data[0][0];
    for (int unsigned i = 1; i < N_CH; i++) begin
      case (mode_e'(w_mode[0]))
        MODE_AND: acc = acc & w_data[0][i];
        MODE_OR:  acc = acc | w_data[0][i];
        MODE_XOR: acc = acc ^ w_data[0][i];
        default:  acc = w_data[0][i];
      endcase
      w_prefix[i] = acc;
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_stage
    if (k == 0) begin : g_capture
      assign w_vin[k] = in_valid;
      assign w_din[k] = in_data;
      assign w_min[k] = in_mode;
    end else if (k == 1) begin : g_result
      assign w_vin[k] = w_valid[0];
      assign w_din[k] = w_prefix;
      assign w_min[k] = w_mode[0];
    end else begin : g_delay
      assign w_vin[k] = w_valid[k-1];
      assign w_din[k] = w_data[k-1];
      assign w_min[k] = w_mode[k-1];
    end

    cascade_pipe_stage #(
      .W(N_CH)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_adv  (w_adv[k]),
      .i_valid(w_vin[k]),
      .i_data (w_din[k]),
      .i_mode (w_min[k]),
      .o_valid(w_valid[k]),
      .o_data (w_data[k]),
      .o_mode (w_mode[k])
    );
  end

  assign in_ready  = w_adv[0];
  assign out_valid = w_valid[L-1];
  assign out_data  = w_data[L-1];
  assign out_mode  = w_mode[L-1];

endmodule
